// File: rtl/cntdown_ctrl_if.sv
// Signal bundle between the button/datapath side (master) and cntdown_ctrl (slave).
interface cntdown_ctrl_if;
  logic       start_pls;
  logic       stop_pls;
  logic       clear_pls;
  logic [7:0] preset_bcd;
  logic [3:0] seg_val1;
  logic [3:0] seg_val0;
  logic       tick;
  logic       dp_n_rst;
  logic       running;
  logic       done;
  logic       done_pls;
  logic       blank;

  modport master (
    output start_pls, stop_pls, clear_pls, preset_bcd, seg_val1, seg_val0,
    input  tick, dp_n_rst, running, done, done_pls, blank
  );

  modport slave (
    input  start_pls, stop_pls, clear_pls, preset_bcd, seg_val1, seg_val0,
    output tick, dp_n_rst, running, done, done_pls, blank
  );
endinterface

// File: rtl/cntdown_ctrl.sv
// Sequencer for the two-digit BCD countdown datapath: clear, fast-forward load, run/pause, done.
// Define CNTDOWN_CTRL_BLINK_EN to blink the display (blank) at 1 Hz while in DONE.
module cntdown_ctrl #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic          clk,
  input  logic          n_rst,
  cntdown_ctrl_if.slave bus
);
  localparam int PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
`ifdef CNTDOWN_CTRL_BLINK_EN
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_FREQ / 2 - 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic          r_halt, w_halt_next;
  logic [7:0]    r_preset;
  logic [PW-1:0] r_presc;
  logic          r_tick, r_dp_n_rst, r_running, r_done, r_done_pls, r_blank;
  logic          w_tick_next, w_blank_next;
  logic [7:0]    w_value;
  logic          w_match, w_value_zero, w_presc_last;
  logic          w_clear, w_stop, w_start;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  assign w_value      = {bus.seg_val1, bus.seg_val0};
  assign w_match      = (w_value == r_preset);
  assign w_value_zero = (w_value == 8'h00);
  assign w_presc_last = (r_presc == PRESC_LAST);

  // Coinciding pulses resolve as clear > stop > start.
  assign w_clear = bus.clear_pls;
  assign w_stop  = bus.stop_pls & ~bus.clear_pls;
  assign w_start = bus.start_pls & ~bus.stop_pls & ~bus.clear_pls;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_halt  <= w_halt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_halt_next  = r_halt;
    if (w_clear) begin
      w_state_next = S_CLEAR;
      w_halt_next  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            w_state_next = S_CLEAR;
            w_halt_next  = 1'b0;
          end
        end
        S_CLEAR: w_state_next = S_LOAD;
        S_LOAD: begin
          // r_tick low marks a check cycle: the datapath has settled after the last tick.
          if (!r_tick && w_match) begin
            if (r_halt)                  w_state_next = S_IDLE;
            else if (r_preset == 8'h00)  w_state_next = S_DONE;
            else                         w_state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (w_value_zero)  w_state_next = S_DONE;
          else if (w_stop)   w_state_next = S_PAUSE;
        end
        S_PAUSE: begin
          if (w_start) w_state_next = S_RUN;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_tick_next  = 1'b0;
    w_blank_next = 1'b0;
    case (r_state)
      S_CLEAR: w_tick_next = (w_state_next == S_LOAD) && (r_preset != 8'h00);
      S_LOAD:  w_tick_next = (w_state_next == S_LOAD) && !r_tick && !w_match;
      S_RUN:   w_tick_next = (w_state_next == S_RUN) && w_presc_last && !w_value_zero;
      default: w_tick_next = 1'b0;
    endcase
`ifdef CNTDOWN_CTRL_BLINK_EN
    if ((r_state == S_DONE) && (w_state_next == S_DONE))
      w_blank_next = (w_presc_last || (r_presc == PRESC_HALF)) ? ~r_blank : r_blank;
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_tick     <= 1'b0;
      r_dp_n_rst <= 1'b0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_done_pls <= 1'b0;
      r_blank    <= 1'b0;
      r_preset   <= 8'h00;
      r_presc    <= '0;
    end else begin
      r_tick     <= w_tick_next;
      r_dp_n_rst <= (w_state_next != S_CLEAR);
      r_running  <= (w_state_next == S_RUN);
      r_done     <= (w_state_next == S_DONE);
      r_done_pls <= (w_state_next == S_DONE) && (r_state != S_DONE);
      r_blank    <= w_blank_next;
      if (w_state_next == S_CLEAR)
        r_preset <= {clamp9(bus.preset_bcd[7:4]), clamp9(bus.preset_bcd[3:0])};
      // Held through LOAD and PAUSE; DONE keeps counting for blink timing.
      if (r_state == S_CLEAR)
        r_presc <= '0;
      else if ((r_state == S_RUN) || (r_state == S_DONE))
        r_presc <= w_presc_last ? '0 : r_presc + PW'(1);
    end
  end

  assign bus.tick     = r_tick;
  assign bus.dp_n_rst = r_dp_n_rst;
  assign bus.running  = r_running;
  assign bus.done     = r_done;
  assign bus.done_pls = r_done_pls;
  assign bus.blank    = r_blank;
endmodule

// File: tb/tb_cntdown_ctrl.sv
// Directed/randomized bench for cntdown_ctrl with a behavioural BCD countdown datapath (CLK_FREQ=10).
module tb_cntdown_ctrl;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dp_val = 0;

  cntdown_ctrl_if bus ();

  cntdown_ctrl #(.CLK_FREQ(10)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Datapath: sync clear to 00, decrement per tick with 00 -> 99 wrap.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.dp_n_rst)  dp_val <= 0;
    else if (bus.tick)  dp_val <= (dp_val == 0) ? 99 : dp_val - 1;
  end
  assign bus.seg_val1 = 4'(dp_val / 10);
  assign bus.seg_val0 = 4'(dp_val % 10);

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_dec(input logic [7:0] raw);
    int hi, lo;
    hi = (raw[7:4] > 4'd9) ? 9 : int'(raw[7:4]);
    lo = (raw[3:0] > 4'd9) ? 9 : int'(raw[3:0]);
    return hi * 10 + lo;
  endfunction

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start (optionally with clear) at this negedge, then follow CLEAR and LOAD to their exit.
  task automatic load_phase(input logic [7:0] raw, input logic clr);
    int p, n_exp, n, b2b, zs, ex;
    logic prev;
    p = clamp_dec(raw);
    n_exp = (100 - p) % 100;
    n = 0; b2b = 0; zs = 0; ex = -2; prev = 1'b0;
    bus.preset_bcd = raw;
    bus.clear_pls  = clr;
    bus.start_pls  = 1'b1;
    @(negedge clk);
    bus.clear_pls  = 1'b0;
    bus.start_pls  = 1'b0;
    chk("clear_dp_n_rst", bus.dp_n_rst, 0);
    chk("clear_quiet", {bus.tick, bus.running, bus.done, bus.blank}, 0);
    @(negedge clk);
    chk("load_first_tick", bus.tick, (p != 0));
    for (int i = 0; i < 400; i++) begin
      if (bus.running || bus.done) begin
        ex = i;
        break;
      end
      if (bus.tick) begin
        n++;
        if (prev) b2b++;
        zs = 0;
      end else begin
        zs++;
        if (zs == 3) begin
          ex = -1;
          break;
        end
      end
      prev = bus.tick;
      @(negedge clk);
    end
    chk("load_ticks", n, n_exp);
    chk("load_alternate", b2b, 0);
    chk("load_value", dp_val, p);
    if (clr) begin
      chk("halt_to_idle", ex, -1);
      chk("halt_flags", {bus.running, bus.done}, 0);
    end else begin
      chk("load_exit_cycle", ex, (n_exp == 0) ? 1 : 2 * n_exp);
      chk("load_exit_running", bus.running, (p != 0));
      chk("load_exit_done", bus.done, (p == 0));
      if (p == 0) chk("done_pls_from_load", bus.done_pls, 1);
    end
    $display("load: preset=%02h clamped=%0d clear=%0b ticks=%0d exit=%0d", raw, p, clr, n, ex);
  endtask

  // Follow RUN until done_pls; last_init is the reference cycle for the first tick spacing.
  task automatic run_to_done(input int exp_ticks, input int last_init);
    int n, bad, last, dl;
    n = 0; bad = 0; last = last_init; dl = -1;
    for (int i = 0; i < 1500; i++) begin
      if (bus.tick) begin
        n++;
        if (cyc - last != 10) bad++;
        last = cyc;
      end
      if (bus.done_pls) begin
        dl = cyc - last;
        break;
      end
      @(negedge clk);
    end
    chk("run_ticks", n, exp_ticks);
    chk("run_tick_period", bad, 0);
    chk("done_pls_latency", dl, 2);
    chk("done_state", {bus.done, bus.running}, 2'b10);
    chk("done_blank_entry", bus.blank, 0);
    chk("done_value", dp_val, 0);
    @(negedge clk);
    chk("done_pls_single", bus.done_pls, 0);
    $display("run: ticks=%0d done_latency=%0d", n, dl);
  endtask

  task automatic blink_check();
    int tog, badsp, lastt;
    logic prev;
    tog = 0; badsp = 0; lastt = -1;
    prev = bus.blank;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.blank !== prev) begin
        tog++;
        if (lastt >= 0 && cyc - lastt != 5) badsp++;
        lastt = cyc;
      end
      prev = bus.blank;
    end
`ifdef CNTDOWN_CTRL_BLINK_EN
    chk("blink_toggles", tog, 4);
    chk("blink_spacing", badsp, 0);
`else
    chk("blank_toggles", tog, 0);
    chk("blank_low", bus.blank, 0);
`endif
    $display("blink: toggles=%0d in 20 cycles", tog);
  endtask

  initial begin
    int nt, ft, r, p3;
    logic [7:0] raw2, raw3;
    bus.start_pls  = 1'b0;
    bus.stop_pls   = 1'b0;
    bus.clear_pls  = 1'b0;
    bus.preset_bcd = 8'h00;
    #2 n_rst = 1'b0;
    cyc_wait(3);
    chk("rst_outputs", {bus.tick, bus.dp_n_rst, bus.running, bus.done, bus.done_pls, bus.blank}, 0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("rel_dp_n_rst", bus.dp_n_rst, 1);
    chk("rel_running", bus.running, 0);
    bus.stop_pls = 1'b1;
    @(negedge clk);
    bus.stop_pls = 1'b0;
    cyc_wait(2);
    chk("idle_stop_ignored", {bus.dp_n_rst, bus.running, bus.tick}, 3'b100);
    $display("reset: done");

    // Preset 15: 85 LOAD ticks, then 15 RUN ticks.
    load_phase(8'h15, 1'b0);
    run_to_done(15, cyc);
    blink_check();

    // Preset 03: stop at prescaler 4, resume 50 cycles later.
    load_phase(8'h03, 1'b0);
    cyc_wait(4);
    bus.stop_pls = 1'b1;
    @(negedge clk);
    bus.stop_pls = 1'b0;
    chk("pause_running", bus.running, 0);
    nt = 0;
    for (int i = 0; i < 49; i++) begin
      if (bus.tick) nt++;
      @(negedge clk);
    end
    chk("pause_no_ticks", nt, 0);
    bus.start_pls = 1'b1;
    r = cyc;
    @(negedge clk);
    bus.start_pls = 1'b0;
    ft = -1;
    for (int i = 0; i < 30; i++) begin
      if (bus.tick) begin
        ft = cyc - r;
        break;
      end
      @(negedge clk);
    end
    chk("resume_tick_latency", ft, 10 - 4);
    $display("pause: ticks_while_paused=%0d resume_latency=%0d", nt, ft);
    run_to_done(3, cyc - 10);

    // Preset 00 goes straight to DONE; 0xAF clamps to 99.
    load_phase(8'h00, 1'b0);
    load_phase(8'hAF, 1'b0);
    cyc_wait($urandom_range(3, 25));

    // Clear+start in RUN: reload new preset, then halt in IDLE.
    raw2 = 8'($urandom);
    load_phase(raw2, 1'b1);
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tick || bus.running) nt++;
      @(negedge clk);
    end
    chk("idle_after_clear_quiet", nt, 0);
    chk("idle_after_clear_value", dp_val, clamp_dec(raw2));
    $display("halt: preset=%02h idle_activity=%0d", raw2, nt);

    // Random preset from IDLE, full countdown.
    raw3 = 8'($urandom_range(1, 255));
    p3 = clamp_dec(raw3);
    load_phase(raw3, 1'b0);
    run_to_done(p3, cyc);

    // Asynchronous reset mid-RUN.
    load_phase(8'h12, 1'b0);
    cyc_wait(3);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_outputs", {bus.tick, bus.dp_n_rst, bus.running, bus.done, bus.done_pls, bus.blank}, 0);
    @(negedge clk);
    chk("async_rst_dp_cleared", dp_val, 0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("async_rel_state", {bus.dp_n_rst, bus.running, bus.tick, bus.done}, 4'b1000);
    $display("async reset: dp_val=%0d", dp_val);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
